// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command sequencer driving an external 8-bit ALU
// Accumulator-style commands in, one response per command out; shifts run locally.
module alu_cmd_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic [2:0] cmd_cnt,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [7:0] alu_out,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_zero,
  output logic [7:0] acc
);

  typedef enum logic [1:0] {IDLE, ISSUE, SHIFT, RESP} state_t;

  localparam logic [3:0] OP_SHL  = 4'b1100;
  localparam logic [3:0] OP_SHR  = 4'b1101;
  localparam logic [3:0] OP_CLR  = 4'b1110;
  localparam logic [3:0] OP_LOAD = 4'b1111;
  localparam logic [3:0] OP_PASS = 4'b0111;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] op_r;
  logic [7:0] b_r;
  logic [7:0] acc_r;
  logic [2:0] cnt_r;
  logic       accept;

  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_op <= 4'b1011)
            state_nxt = ISSUE;
          else if ((cmd_op == OP_SHL || cmd_op == OP_SHR) && cmd_cnt != 3'd0)
            state_nxt = SHIFT;
          else
            state_nxt = RESP;
        end
      end
      ISSUE:   state_nxt = RESP;
      // The last shift happens on the edge where the remaining count is one.
      SHIFT:   if (cnt_r <= 3'd1) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = rst_n && (state == IDLE);
    rsp_valid = rst_n && (state == RESP);
    alu_a     = acc_r;
    alu_b     = 8'h00;
    alu_op    = OP_PASS;
    if (state == ISSUE) begin
      alu_b  = b_r;
      alu_op = op_r;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r <= 8'h00;
      cnt_r <= 3'd0;
      op_r  <= 4'd0;
      b_r   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_r  <= cmd_op;
            b_r   <= cmd_data;
            cnt_r <= cmd_cnt;
            if (cmd_op == OP_CLR)  acc_r <= 8'h00;
            if (cmd_op == OP_LOAD) acc_r <= cmd_data;
          end
        end
        ISSUE: acc_r <= alu_out;
        SHIFT: begin
          acc_r <= (op_r == OP_SHR) ? {1'b0, acc_r[7:1]} : {acc_r[6:0], 1'b0};
          cnt_r <= cnt_r - 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign rsp_data = acc_r;
  assign rsp_zero = (acc_r == 8'h00);
  assign acc      = acc_r;

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Initiator-side controller for the 8-bit combinational ALU: accepts accumulator-style commands over a valid/ready channel and drives the ALU's A/B/Op inputs. It captures the ALU result into an internal 8-bit accumulator and returns each result over a valid/ready response channel. Shift commands execute locally as multi-cycle serial shifts, so the ALU itself is only used for opcodes 0000–1011.

## Interface
Parameters: none. Data width is fixed at 8 bits and opcode width at 4 bits.

Ports, one clock domain; reset is synchronous and active-low:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  4  opcode, same encoding as the ALU's Op
- cmd_data  in  8  operand B, or load value
- cmd_cnt  in  3  shift count (0–7), used by ops 1100/1101 only
- alu_a  out  8  to ALU A
- alu_b  out  8  to ALU B
- alu_op  out  4  to ALU Op
- alu_out  in  8  from ALU Out (combinational)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  8  accumulator value
- rsp_zero  out  1  rsp_data == 0
- acc  out  8  live accumulator

## Operation
- States:
  - IDLE: cmd_ready=1.
  - ISSUE: one cycle.
  - SHIFT: cmd_cnt cycles.
  - RESP: rsp_valid=1.
- Command accepted when cmd_valid && cmd_ready at a rising edge. The sequencer latches op, data and cnt into op_r, b_r, cnt_r.
- Transition from IDLE on accept:
  - op 0000–1011 -> ISSUE.
  - op 1100/1101 with cnt≠0 -> SHIFT.
  - op 1100/1101 with cnt=0 -> RESP; ACC unchanged.
  - op 1110 -> RESP with ACC<=0x00.
  - op 1111 -> RESP with ACC<=cmd_data.
- ISSUE: drive alu_a=ACC, alu_b=b_r, alu_op=op_r. At the end of the cycle ACC<=alu_out, then -> RESP.
- SHIFT: each cycle ACC shifts by 1 and cnt_r decrements; -> RESP when cnt_r reaches 0 after the shift.
  - 1100: ACC<={ACC[6:0],1'b0}.
  - 1101: ACC<={1'b0,ACC[7:1]}.
  - Zero fill, no rotate.
- RESP: rsp_data=ACC and rsp_zero=(ACC==0). Both are held stable until rsp_ready; on rsp_ready -> IDLE.
- ALU port values outside ISSUE: alu_a=ACC, alu_b=0x00, alu_op=4'b0111 (pass A).
- Arithmetic is the ALU's 8-bit result, so wrap-around is inherent: carry and borrow are discarded and no flags other than rsp_zero exist.
- Only one command is outstanding at a time; cmd_ready=0 in ISSUE, SHIFT and RESP.
- Reset (rst_n=0 at an edge):
  - state<=IDLE, ACC<=0x00, cnt_r<=0.
  - While rst_n is low: cmd_ready=0 and rsp_valid=0.
  - Outputs after the reset edge: rsp_data=0x00, rsp_zero=1, acc=0x00, alu_a=0x00, alu_b=0x00, alu_op=0111.
  - Reset mid-ISSUE, mid-SHIFT or mid-RESP aborts the command silently; no response is issued.

## Timing
- Cycle 0 is the accepting edge.
- Latency from accept to rsp_valid:
  - Ops 0000–1011: rsp_valid high from cycle 2 (ISSUE in cycle 1).
  - Shift by n≥1: rsp_valid high from cycle 1+n.
  - Shift by 0, op 1110, op 1111: rsp_valid high from cycle 1.
- Backpressure: rsp_valid stays high and rsp_data stays constant while rsp_ready=0. The response completes at the first edge with rsp_ready=1.
- The earliest next accept is the edge after response completion. Back-to-back maximum throughput for ALU ops is one command per 3 cycles.
- cmd_valid held during non-IDLE states is ignored and is not consumed.
- alu_out is sampled only at the ISSUE edge. ALU combinational delay plus setup must fit in one clk period.
- rsp_zero is combinational from ACC, so it is valid whenever rsp_valid is high.

## Test plan
- Reset, then op 1111 with data 0xF0 -> rsp_valid at cycle 1, rsp_data=0xF0, rsp_zero=0, acc=0xF0.
- Next, op 1000 with data 0x20 -> in ISSUE, alu_a=0xF0, alu_b=0x20, alu_op=1000. rsp_valid at cycle 2 with rsp_data=0x10 (wrap, carry dropped).
- Next, op 1100 with cnt=3 -> ACC 0x10->0x20->0x40->0x80; rsp_valid at cycle 4, rsp_data=0x80. Then op 1101 with cnt=7 -> rsp_data=0x01 at cycle 8. Then op 1101 with cnt=0 -> rsp_data=0x01 at cycle 1.
- Backpressure: op 1001 with data 0x01 on ACC=0x01 -> rsp_data=0x00, rsp_zero=1. Hold rsp_ready=0 for 5 cycles: rsp_valid, rsp_data and rsp_zero stay constant and cmd_ready stays 0 while cmd_valid is held high. Release rsp_ready: IDLE next cycle, and the held command is accepted on the following edge.
- Reset mid-shift: op 1111 with data 0xFF, then op 1100 with cnt=7; assert rst_n=0 at cycle 3 -> next edge ACC=0x00, state IDLE. No rsp_valid pulse occurs, and cmd_ready=1 once rst_n is high.
- Logic sweep: ACC=0xA5 with data 0x3C for each op 0000–0111 -> responses 0x24, 0xBD, 0x99, 0x66, 0x5A, 0xDB, 0x42, 0xA5 respectively. Each step reloads ACC=0xA5 via op 1111 first.
